// File: rtl/ring_osc_trim_ctrl.sv
// ring_osc_trim_ctrl: frequency-lock loop for a trimmable ring oscillator.
// Runs on the oscillator clock and counts oscillator cycles per reference
// period. It steps a thermometer trim code one unit per reference period
// toward the divider target and flags lock after LOCK_CNT in-band periods.
// Optional feature: define RING_OSC_TRIM_OVERRIDE_EN to add an external
// trim override (ports i_ext_trim_en / i_ext_trim).
`timescale 1ns/1ps
module ring_osc_trim_ctrl #(
  parameter int NSTAGE    = 13,
  parameter int DIVW      = 8,
  parameter int CNTW      = 10,
  parameter int TOL       = 1,
  parameter int LOCK_CNT  = 4,
  parameter int INIT_CODE = 0
) (
  input  logic                            i_clock,
  input  logic                            i_resetb,
  input  logic                            i_enable,
  input  logic                            i_ref,
  input  logic [DIVW-1:0]                 i_div,
  output logic [2*NSTAGE-1:0]             o_trim,
  output logic [$clog2(2*NSTAGE+1)-1:0]   o_code,
  output logic                            o_locked
`ifdef RING_OSC_TRIM_OVERRIDE_EN
  ,
  input  logic                            i_ext_trim_en,
  input  logic [2*NSTAGE-1:0]             i_ext_trim
`endif
);

  localparam int TRIMW = 2 * NSTAGE;
  localparam int CODEW = $clog2(2 * NSTAGE + 1);
  localparam int LCW   = $clog2(LOCK_CNT + 1);
  localparam int CMPW  = CNTW + 1;

  localparam logic [CODEW-1:0] CODE_MAX  = CODEW'(TRIMW);
  localparam logic [CODEW-1:0] CODE_INIT = CODEW'(INIT_CODE);
  localparam logic [CODEW-1:0] CODE_ONE  = CODEW'(1);
  localparam logic [CNTW-1:0]  CNT_MAX   = {CNTW{1'b1}};
  localparam logic [CNTW-1:0]  CNT_ONE   = CNTW'(1);
  localparam logic [LCW-1:0]   LOCK_TGT  = LCW'(LOCK_CNT);
  localparam logic [LCW-1:0]   LCTR_ONE  = LCW'(1);
  localparam logic [CMPW-1:0]  TOL_EXT   = CMPW'(TOL);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ARM    = 2'd1;
  localparam logic [1:0] S_TRACK  = 2'd2;
  localparam logic [1:0] S_LOCKED = 2'd3;

  // Thermometer map: bit i is set when the code exceeds i. Primary bits
  // [NSTAGE-1:0] fill first, so a secondary bit never appears without its primary.
  function automatic logic [TRIMW-1:0] therm(input logic [CODEW-1:0] k);
    logic [TRIMW-1:0] t;
    t = {TRIMW{1'b0}};
    for (int i = 0; i < TRIMW; i++) begin
      t[i] = (int'(k) > i);
    end
    return t;
  endfunction

  logic               r_ref_s1, r_ref_s2, r_ref_d;
  logic [CNTW-1:0]    r_cnt;
  logic [1:0]         r_state;
  logic [CODEW-1:0]   r_code;
  logic [TRIMW-1:0]   r_trim;
  logic [LCW-1:0]     r_lock_ctr;
  logic               r_locked;

  logic               w_ref_rise;
  logic               w_ovr;
  logic [CMPW-1:0]    w_per_ext, w_div_ext, w_hi, w_lo;
  logic               w_fast, w_slow;
  logic [1:0]         w_state_nxt;
  logic [CODEW-1:0]   w_code_nxt;
  logic [LCW-1:0]     w_lock_ctr_nxt;
  logic               w_locked_nxt;
  logic [TRIMW-1:0]   w_trim_nxt;

  assign w_ref_rise = r_ref_s2 & ~r_ref_d;

`ifdef RING_OSC_TRIM_OVERRIDE_EN
  assign w_ovr      = i_ext_trim_en;
  assign w_trim_nxt = i_ext_trim_en ? i_ext_trim : therm(w_code_nxt);
`else
  assign w_ovr      = 1'b0;
  assign w_trim_nxt = therm(w_code_nxt);
`endif

  // Band limits in CNTW+1 bits. The lower limit clamps at zero when div < TOL,
  // and a saturated count is always treated as too fast.
  assign w_per_ext = {1'b0, r_cnt};
  assign w_div_ext = {{(CMPW-DIVW){1'b0}}, i_div};
  assign w_hi      = w_div_ext + TOL_EXT;
  assign w_lo      = (w_div_ext >= TOL_EXT) ? (w_div_ext - TOL_EXT) : {CMPW{1'b0}};
  assign w_fast    = (r_cnt == CNT_MAX) || (w_per_ext > w_hi);
  assign w_slow    = !w_fast && (w_per_ext < w_lo);

  // Two-flop synchronizer for the asynchronous reference, plus an edge-detect flop
  always_ff @(posedge i_clock or negedge i_resetb) begin
    if (!i_resetb) begin
      r_ref_s1 <= 1'b0;
      r_ref_s2 <= 1'b0;
      r_ref_d  <= 1'b0;
    end else begin
      r_ref_s1 <= i_ref;
      r_ref_s2 <= r_ref_s1;
      r_ref_d  <= r_ref_s2;
    end
  end

  // Saturating period counter; restarts at 1 on each reference rise
  always_ff @(posedge i_clock or negedge i_resetb) begin
    if (!i_resetb) begin
      r_cnt <= {CNTW{1'b0}};
    end else if (w_ref_rise) begin
      r_cnt <= CNT_ONE;
    end else if (r_cnt != CNT_MAX) begin
      r_cnt <= r_cnt + CNT_ONE;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  // Tracking FSM: next state, trim code and lock bookkeeping
  always_comb begin
    w_state_nxt    = r_state;
    w_code_nxt     = r_code;
    w_lock_ctr_nxt = r_lock_ctr;
    w_locked_nxt   = r_locked;
    if (!i_enable) begin
      w_state_nxt    = S_IDLE;
      w_code_nxt     = CODE_INIT;
      w_lock_ctr_nxt = {LCW{1'b0}};
      w_locked_nxt   = 1'b0;
    end else if (w_ovr) begin
      w_state_nxt    = S_IDLE;
      w_lock_ctr_nxt = {LCW{1'b0}};
      w_locked_nxt   = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_nxt = S_ARM;
        end
        S_ARM: begin
          // The partial period in flight when tracking starts is discarded
          if (w_ref_rise) begin
            w_state_nxt = S_TRACK;
          end else begin
            w_state_nxt = S_ARM;
          end
        end
        S_TRACK, S_LOCKED: begin
          if (w_ref_rise && w_fast) begin
            w_code_nxt     = (r_code == CODE_MAX) ? CODE_MAX : (r_code + CODE_ONE);
            w_lock_ctr_nxt = {LCW{1'b0}};
            w_locked_nxt   = 1'b0;
            w_state_nxt    = S_TRACK;
          end else if (w_ref_rise && w_slow) begin
            w_code_nxt     = (r_code == {CODEW{1'b0}}) ? r_code : (r_code - CODE_ONE);
            w_lock_ctr_nxt = {LCW{1'b0}};
            w_locked_nxt   = 1'b0;
            w_state_nxt    = S_TRACK;
          end else if (w_ref_rise) begin
            w_lock_ctr_nxt = (r_lock_ctr >= LOCK_TGT) ? r_lock_ctr : (r_lock_ctr + LCTR_ONE);
            if (w_lock_ctr_nxt >= LOCK_TGT) begin
              w_locked_nxt = 1'b1;
              w_state_nxt  = S_LOCKED;
            end else begin
              w_locked_nxt = r_locked;
              w_state_nxt  = r_state;
            end
          end else begin
            w_state_nxt = r_state;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // Control state and registered outputs
  always_ff @(posedge i_clock or negedge i_resetb) begin
    if (!i_resetb) begin
      r_state    <= S_IDLE;
      r_code     <= CODE_INIT;
      r_trim     <= therm(CODE_INIT);
      r_lock_ctr <= {LCW{1'b0}};
      r_locked   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_code     <= w_code_nxt;
      r_trim     <= w_trim_nxt;
      r_lock_ctr <= w_lock_ctr_nxt;
      r_locked   <= w_locked_nxt;
    end
  end

  assign o_trim   = r_trim;
  assign o_code   = r_code;
  assign o_locked = r_locked;

endmodule

// File: tb/tb_ring_osc_trim_ctrl.sv
// Directed bench for ring_osc_trim_ctrl (default build, override feature off).
// The reference is driven as "gap then rising edge" so that every rise-to-rise
// interval is exactly the requested number of oscillator clocks.
`timescale 1ns/1ps
module tb_ring_osc_trim_ctrl;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        ref_in;
  logic [7:0]  div;
  logic [25:0] trim;
  logic [4:0]  code;
  logic        locked;

  int n_cmp;
  int n_fail;

  ring_osc_trim_ctrl dut (
    .i_clock  (clk),
    .i_resetb (rst_n),
    .i_enable (en),
    .i_ref    (ref_in),
    .i_div    (div),
    .o_trim   (trim),
    .o_code   (code),
    .o_locked (locked)
  );

  // free-running oscillator clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Rising edge of ref, then hold high 4 clocks (evaluation lands within 3)
  task automatic ref_edge();
    ref_in = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  // Low phase so that the next ref_edge comes n clocks after the previous one
  task automatic ref_gap(input int n);
    ref_in = 1'b0;
    repeat (n - 4) @(negedge clk);
  endtask

  // One full reference period of n oscillator clocks ending with a rise
  task automatic ref_period(input int n);
    ref_gap(n);
    ref_edge();
  endtask

  // Drop enable for one clock, re-enable, then spend the discarded first period
  task automatic restart();
    en = 1'b0;
    @(negedge clk);
    check("dis_code", code, 0);
    en = 1'b1;
    @(negedge clk);
    ref_period(10);
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    clk    = 1'b0;
    rst_n  = 1'b0;
    en     = 1'b1;
    ref_in = 1'b0;
    div    = 8'd20;

    // reset held with enable and ref toggling: nothing moves
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      ref_in = ~ref_in;
      repeat (3) @(negedge clk);
      check("rst_code", code, 0);
      check("rst_trim", trim, 0);
      check("rst_lock", locked, 0);
    end
    en     = 1'b0;
    ref_in = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_code", code, 0);

    // slow-down ramp: div=20, 40 clocks per ref period
    en = 1'b1;
    @(negedge clk);
    ref_period(10);
    check("ramp_discard", code, 0);
    ref_period(40);
    check("ramp_code1", code, 1);
    check("ramp_trim1", trim, 32'h1);
    repeat (4) ref_period(40);
    check("ramp_code5", code, 5);
    check("ramp_trim5", trim, 32'h1F);
    repeat (25) ref_period(40);
    check("ramp_sat_code", code, 26);
    check("ramp_sat_trim", trim, 32'h3FF_FFFF);
    check("ramp_lock", locked, 0);

    // lock: period = 40 - 2*code, div=24
    div = 8'd24;
    restart();
    check("lock_start", code, 0);
    for (int i = 0; i < 8; i++) begin
      ref_period(40 - 2 * i);
      check("lock_ramp", code, i + 1);
    end
    for (int i = 0; i < 4; i++) begin
      ref_period(24);
      check("lock_hold", code, 8);
      check("lock_flag", locked, (i == 3) ? 1 : 0);
    end
    check("lock_trim", trim, 32'hFF);
    ref_period(30);
    check("unlock_flag", locked, 0);
    check("unlock_code", code, 9);

    // div=0: ramps to the top and stays
    div = 8'd0;
    restart();
    repeat (30) ref_period(10);
    check("div0_code", code, 26);

    // too slow: step down from the top
    div = 8'd200;
    repeat (3) ref_period(20);
    check("slow_code", code, 23);
    check("slow_trim", trim, 32'h7F_FFFF);

    // period 5 against div=200 stays at 0
    restart();
    repeat (3) ref_period(5);
    check("slow_floor", code, 0);

    // counter saturation: 1100 clocks would wrap to 76 without saturation
    ref_period(1100);
    check("cnt_sat_fast", code, 1);

    // enable drop at code 12
    div = 8'd0;
    restart();
    repeat (12) ref_period(10);
    check("mid_code12", code, 12);
    en = 1'b0;
    @(negedge clk);
    check("dis_code0", code, 0);
    check("dis_trim0", trim, 0);
    check("dis_lock0", locked, 0);
    en = 1'b1;
    @(negedge clk);
    ref_period(10);
    check("reen_discard", code, 0);
    ref_period(10);
    check("reen_first", code, 1);
    repeat (11) ref_period(10);
    check("pre_rst_code", code, 12);

    // asynchronous reset mid-cycle
    #2 rst_n = 1'b0;
    #1;
    check("async_code", code, 0);
    check("async_trim", trim, 0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
